scatter2d_stub: RTL and testbench

- Write-back counterpart of the block-structured gather engine: streams s_tokens × head_dim_d words out of the core output (O) scratchpad.
- Scatters each word to an external write port at a block-indexed, strided destination address. Block IDs come from the shared index RAM.
- Sits between the attention core's O buffer and the DMA/memory write path.
- Supports output backpressure through a 2-entry output FIFO.

---
 rtl/scatter2d_stub.sv | 189 ++++++++++++++++++
 tb/tb_scatter2d_stub.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scatter2d_stub.sv
// Write-back scatter engine: streams tokens x dims out of the O scratchpad and
// writes each word to a block-indexed, strided destination through a 2-entry FIFO.
//
// state | meaning
// IDLE  | waiting for start; configuration latched on launch
// RUN   | issuing one O/index read per cycle while FIFO space allows
// DRAIN | reads finished; waiting for in-flight word and FIFO to empty
// DONE  | one-cycle completion pulse
module scatter2d_stub #(
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       s_tokens,
  input  logic [15:0]       head_dim_d,
  input  logic [15:0]       block_size,
  input  logic [15:0]       stride_d,
  input  logic [15:0]       stride_t,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              o_ren,
  output logic [15:0]       o_raddr,
  input  logic [31:0]       o_rdata,
  output logic [15:0]       idx_rd_addr,
  input  logic [15:0]       idx_rd_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;

  logic [15:0]       n_tok, n_dim, blk_sz, str_d, str_t;
  logic [ADDR_W-1:0] base;

  logic [15:0] d_cnt, t_cnt, tib_cnt, blk_cnt, lin;

  logic        inflight;
  logic [15:0] d_q, tib_q;

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [31:0]       fifo_data [FIFO_DEPTH];
  logic              rd_ptr, wr_ptr;
  logic [1:0]        count;

  logic              pop, push, issue, last_d, last_t, block_wrap, drain_exit;
  logic [2:0]        occ;
  logic [ADDR_W-1:0] ret_addr;

  assign wr_valid = (count != 2'd0);
  assign pop      = wr_valid & wr_ready;
  assign push     = inflight;

  // Occupancy after this cycle's pop; the in-flight word already owns a slot.
  assign occ   = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign issue = (state == RUN) && (occ < 3'(FIFO_DEPTH));

  assign o_ren       = issue;
  assign o_raddr     = (state == RUN) ? lin : 16'd0;
  assign idx_rd_addr = (state == RUN) ? blk_cnt : 16'd0;

  assign last_d     = (d_cnt == n_dim - 16'd1);
  assign last_t     = (t_cnt == n_tok - 16'd1);
  assign block_wrap = (blk_sz != 16'd0) && (tib_cnt == blk_sz - 16'd1);

  // With block_size==0 the block term vanishes and tib carries the full token index.
  assign ret_addr = base
                  + (ADDR_W'(idx_rd_data) * ADDR_W'(blk_sz) + ADDR_W'(tib_q)) * ADDR_W'(str_t)
                  + ADDR_W'(d_q) * ADDR_W'(str_d);

  // Leaving on the cycle of the final pop makes done follow the last handshake directly.
  assign drain_exit = !inflight && ((count == 2'd0) || ((count == 2'd1) && pop));

  assign wr_addr = wr_valid ? fifo_addr[rd_ptr] : '0;
  assign wr_data = wr_valid ? fifo_data[rd_ptr] : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      inflight <= 1'b0;
      d_q      <= 16'd0;
      tib_q    <= 16'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr[i] <= '0;
        fifo_data[i] <= 32'd0;
      end
    end else begin
      inflight <= issue;
      if (issue) begin
        d_q   <= d_cnt;
        tib_q <= tib_cnt;
      end
      if (push) begin
        fifo_addr[wr_ptr] <= ret_addr;
        fifo_data[wr_ptr] <= o_rdata;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      n_tok   <= 16'd0;
      n_dim   <= 16'd0;
      blk_sz  <= 16'd0;
      str_d   <= 16'd0;
      str_t   <= 16'd0;
      base    <= '0;
      d_cnt   <= 16'd0;
      t_cnt   <= 16'd0;
      tib_cnt <= 16'd0;
      blk_cnt <= 16'd0;
      lin     <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            n_tok   <= s_tokens;
            n_dim   <= head_dim_d;
            blk_sz  <= block_size;
            str_d   <= stride_d;
            str_t   <= stride_t;
            base    <= dst_base;
            d_cnt   <= 16'd0;
            t_cnt   <= 16'd0;
            tib_cnt <= 16'd0;
            blk_cnt <= 16'd0;
            lin     <= 16'd0;
            if (s_tokens == 16'd0 || head_dim_d == 16'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            lin <= lin + 16'd1;
            if (last_d) begin
              d_cnt <= 16'd0;
              t_cnt <= t_cnt + 16'd1;
              if (block_wrap) begin
                tib_cnt <= 16'd0;
                blk_cnt <= blk_cnt + 16'd1;
              end else begin
                tib_cnt <= tib_cnt + 16'd1;
              end
              if (last_t) state <= DRAIN;
            end else begin
              d_cnt <= d_cnt + 16'd1;
            end
          end
        end
        DRAIN: begin
          if (drain_exit) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scatter2d_stub.sv
// Scoreboard bench for scatter2d_stub: directed cases push expected beats,
// a negedge monitor pops and compares on every write handshake.
module tb_scatter2d_stub;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] s_tokens, head_dim_d, block_size, stride_d, stride_t;
  logic [31:0] dst_base;
  logic        o_ren;
  logic [15:0] o_raddr;
  logic [31:0] o_rdata = 32'd0;
  logic [15:0] idx_rd_addr;
  logic [15:0] idx_rd_data = 16'd0;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_addr, wr_data;
  logic        busy, done;

  always #5 clk = ~clk;

  scatter2d_stub #(.FIFO_DEPTH(2), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_tokens(s_tokens), .head_dim_d(head_dim_d), .block_size(block_size),
    .stride_d(stride_d), .stride_t(stride_t), .dst_base(dst_base),
    .o_ren(o_ren), .o_raddr(o_raddr), .o_rdata(o_rdata),
    .idx_rd_addr(idx_rd_addr), .idx_rd_data(idx_rd_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  logic [31:0] o_mem [64];
  logic [15:0] idx_mem [16];

  always @(posedge clk) begin
    if (o_ren) begin
      o_rdata     <= o_mem[o_raddr[5:0]];
      idx_rd_data <= idx_mem[idx_rd_addr[3:0]];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_fail = 0;
  logic [31:0] exp_addr_q [$];
  logic [31:0] exp_data_q [$];

  int hs_cnt, done_cnt, busy_cnt, ren_cnt, valid_cnt;
  int first_hs, last_hs, done_cyc, n_out;
  logic stall = 1'b0;
  logic [31:0] p_addr, p_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] ea, ed;
    if (rst) begin
      n_out = 0;
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("hold_valid", {31'd0, wr_valid}, 32'd1);
        check("hold_addr", wr_addr, p_addr);
        check("hold_data", wr_data, p_data);
      end
      if (o_ren) ren_cnt++;
      if (wr_valid) valid_cnt++;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (wr_valid && wr_ready) begin
        if (hs_cnt == 0) first_hs = cyc;
        last_hs = cyc;
        hs_cnt++;
        if (exp_addr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got addr 0x%08h data 0x%08h, none expected", wr_addr, wr_data);
        end else begin
          ea = exp_addr_q.pop_front();
          ed = exp_data_q.pop_front();
          check("wr_addr", wr_addr, ea);
          check("wr_data", wr_data, ed);
        end
      end
      n_out = n_out + (o_ren ? 1 : 0) - ((wr_valid && wr_ready) ? 1 : 0);
      if (o_ren) check("outstanding_le2", {31'd0, (n_out <= 2)}, 32'd1);
      stall  = wr_valid && !wr_ready;
      p_addr = wr_addr;
      p_data = wr_data;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_stats();
    hs_cnt = 0; done_cnt = 0; busy_cnt = 0; ren_cnt = 0; valid_cnt = 0;
    first_hs = -1; last_hs = -1; done_cyc = -1;
  endtask

  task automatic expect_beat(input logic [31:0] a, input logic [31:0] d);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
  endtask

  task automatic launch(input logic [15:0] s, input logic [15:0] d, input logic [15:0] bs,
                        input logic [15:0] sd, input logic [15:0] st, input logic [31:0] b,
                        output int t0);
    s_tokens = s; head_dim_d = d; block_size = bs;
    stride_d = sd; stride_t = st; dst_base = b;
    start = 1'b1;
    t0 = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      tick(1);
      k++;
    end
    if (done_cnt == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no done within %0d cycles, required one", name, budget);
    end
    tick(3);
  endtask

  task automatic end_case(input string name, input int beats);
    check({name, "_beats"}, hs_cnt, beats);
    check({name, "_done_count"}, done_cnt, 32'd1);
    check({name, "_queue_left"}, exp_addr_q.size(), 32'd0);
  endtask

  task automatic expect_basic();
    for (int k = 0; k < 8; k++) expect_beat(32'h1028 + k, 32'hC0DE_0000 + k * 17);
  endtask

  int t0;

  initial begin
    rst = 1'b1; start = 1'b0; wr_ready = 1'b1;
    s_tokens = 0; head_dim_d = 0; block_size = 0; stride_d = 0; stride_t = 0; dst_base = 0;
    for (int i = 0; i < 64; i++) o_mem[i] = 32'hC0DE_0000 + i * 17;
    for (int i = 0; i < 16; i++) idx_mem[i] = 16'd0;
    clear_stats();
    tick(3);
    check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("rst_busy_done", {30'd0, busy, done}, 32'd0);
    check("rst_o_ren", {31'd0, o_ren}, 32'd0);
    rst = 1'b0;
    tick(2);

    // Basic: two tokens of four words in block 5.
    idx_mem[0] = 16'd5;
    clear_stats();
    expect_basic();
    launch(16'd2, 16'd4, 16'd2, 16'd1, 16'd4, 32'h1000, t0);
    wait_done("basic", 60);
    end_case("basic", 8);
    check("basic_first_beat_cycle", first_hs - t0, 32'd3);
    check("basic_last_beat_cycle", last_hs - t0, 32'd10);
    check("basic_done_cycle", done_cyc - t0, 32'd11);
    check("basic_busy_cycles", busy_cnt, 32'd10);

    // Backpressure: wr_ready low for five cycles from the first wr_valid.
    clear_stats();
    expect_basic();
    launch(16'd2, 16'd4, 16'd2, 16'd1, 16'd4, 32'h1000, t0);
    tick(2);
    wr_ready = 1'b0;
    check("bp_first_valid", {31'd0, wr_valid}, 32'd1);
    tick(5);
    wr_ready = 1'b1;
    wait_done("bp", 80);
    end_case("bp", 8);

    // Block crossing with distinct block IDs.
    idx_mem[0] = 16'd3; idx_mem[1] = 16'd0; idx_mem[2] = 16'd7;
    clear_stats();
    expect_beat(32'd6, 32'hC0DE_0000);
    expect_beat(32'd7, 32'hC0DE_0011);
    expect_beat(32'd0, 32'hC0DE_0022);
    expect_beat(32'd1, 32'hC0DE_0033);
    expect_beat(32'd14, 32'hC0DE_0044);
    launch(16'd5, 16'd1, 16'd2, 16'd0, 16'd1, 32'd0, t0);
    wait_done("blocks", 60);
    end_case("blocks", 5);

    // Zero tokens: immediate done, no traffic.
    clear_stats();
    launch(16'd0, 16'd4, 16'd2, 16'd1, 16'd4, 32'h1000, t0);
    wait_done("zero", 20);
    check("zero_done_cycle", done_cyc - t0, 32'd1);
    check("zero_no_reads", ren_cnt, 32'd0);
    check("zero_no_valid", valid_cnt, 32'd0);
    check("zero_done_count", done_cnt, 32'd1);

    // block_size 0: single block, idx[0] ignored in the address.
    idx_mem[0] = 16'd1;
    clear_stats();
    expect_beat(32'd0, 32'hC0DE_0000);
    expect_beat(32'd1, 32'hC0DE_0011);
    expect_beat(32'd2, 32'hC0DE_0022);
    launch(16'd3, 16'd1, 16'd0, 16'd0, 16'd1, 32'd0, t0);
    wait_done("bs0", 60);
    end_case("bs0", 3);

    // start pulsed during RUN is ignored.
    idx_mem[0] = 16'd5;
    clear_stats();
    expect_basic();
    launch(16'd2, 16'd4, 16'd2, 16'd1, 16'd4, 32'h1000, t0);
    tick(2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done("restart", 60);
    tick(15);
    end_case("restart", 8);

    // Reset mid-RUN aborts silently.
    clear_stats();
    expect_basic();
    launch(16'd2, 16'd4, 16'd2, 16'd1, 16'd4, 32'h1000, t0);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("abort_o_ren", {31'd0, o_ren}, 32'd0);
    check("abort_o_raddr", {16'd0, o_raddr}, 32'd0);
    check("abort_idx_addr", {16'd0, idx_rd_addr}, 32'd0);
    check("abort_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("abort_wr_addr", wr_addr, 32'd0);
    check("abort_wr_data", wr_data, 32'd0);
    check("abort_busy_done", {30'd0, busy, done}, 32'd0);
    exp_addr_q.delete();
    exp_data_q.delete();
    tick(12);
    check("abort_no_done", done_cnt, 32'd0);

    clear_stats();
    expect_basic();
    launch(16'd2, 16'd4, 16'd2, 16'd1, 16'd4, 32'h1000, t0);
    wait_done("after_abort", 60);
    end_case("after_abort", 8);
    check("after_abort_done_cycle", done_cyc - t0, 32'd11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
